// File: rtl/ram_dma_wrfifo.sv
// rtl/ram_dma_wrfifo.sv - write-posting FIFO from the DMA engine to the SDRAM controller DMA write port
module ram_dma_wrfifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [22:0]                wr_adr,
  input  logic [31:0]                wr_data,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  output logic [22:0]                ram_dmafifo_adr,
  output logic [31:0]                ram_dmafifo_data,
  output logic                       ram_dmafifo_empty,
  input  logic                       ram_dmafifo_read,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow,
  input  logic [22:0]                chk_adr,
  output logic                       chk_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(DEPTH - AFULL_MARGIN);

  logic [54:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_nxt;
  logic          rd_fire;
  logic          wr_fire;
  logic          hit_nxt;
  logic          unused_chk_lsb;

  assign unused_chk_lsb = ^chk_adr[1:0];

  assign level             = level_q;
  assign ram_dmafifo_empty = (level_q == '0);
  assign full              = (level_q == FULL_LVL);
  assign almost_full       = (level_q >= AFULL_LVL);

  assign rd_fire = ram_dmafifo_read && !ram_dmafifo_empty;
  assign wr_fire = wr_en && (!full || rd_fire);

  // Head is show-ahead, but forced to zero so an empty FIFO never exposes stale array data.
  assign {ram_dmafifo_adr, ram_dmafifo_data} = ram_dmafifo_empty ? 55'd0 : mem[rp];

  always_comb begin
    level_nxt = level_q;
    case ({wr_fire, rd_fire})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Query runs against the post-edge contents: window slots minus the popped head, plus the pushed slot.
  always_comb begin
    hit_nxt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_fire && (AW'(i) == wp)) begin
        if (wr_adr[22:2] == chk_adr[22:2]) hit_nxt = 1'b1;
      end else if (({1'b0, AW'(i) - rp} < level_q) && !(rd_fire && (AW'(i) == rp))) begin
        if (mem[i][54:34] == chk_adr[22:2]) hit_nxt = 1'b1;
      end
    end
    if (flush) hit_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !flush) mem[wp] <= {wr_adr, wr_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp        <= '0;
      rp        <= '0;
      level_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      chk_hit   <= 1'b0;
    end else begin
      chk_hit <= hit_nxt;
      if (flush) begin
        wp        <= '0;
        rp        <= '0;
        level_q   <= '0;
        overflow  <= overflow && !clr_err;
        underflow <= underflow && !clr_err;
      end else begin
        if (wr_fire) wp <= wp + AW'(1);
        if (rd_fire) rp <= rp + AW'(1);
        level_q   <= level_nxt;
        overflow  <= (wr_en && !wr_fire) || (overflow && !clr_err);
        underflow <= (ram_dmafifo_read && ram_dmafifo_empty) || (underflow && !clr_err);
      end
    end
  end

endmodule

// File: tb/tb_ram_dma_wrfifo.sv
// tb/tb_ram_dma_wrfifo.sv - self-checking bench for ram_dma_wrfifo
module tb_ram_dma_wrfifo;

  localparam int DEPTH = 16;
  localparam int AFM   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [22:0] wr_adr;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic [4:0]  level;
  logic [22:0] ram_dmafifo_adr;
  logic [31:0] ram_dmafifo_data;
  logic        ram_dmafifo_empty;
  logic        ram_dmafifo_read;
  logic        flush;
  logic        clr_err;
  logic        overflow;
  logic        underflow;
  logic [22:0] chk_adr;
  logic        chk_hit;

  always #5 clk = ~clk;

  ram_dma_wrfifo #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .level(level),
    .ram_dmafifo_adr(ram_dmafifo_adr), .ram_dmafifo_data(ram_dmafifo_data),
    .ram_dmafifo_empty(ram_dmafifo_empty), .ram_dmafifo_read(ram_dmafifo_read),
    .flush(flush), .clr_err(clr_err), .overflow(overflow), .underflow(underflow),
    .chk_adr(chk_adr), .chk_hit(chk_hit)
  );

  int checks = 0;
  int errors = 0;

  logic [54:0] q[$];
  bit m_ovf = 0;
  bit m_udf = 0;
  bit m_hit = 0;

  typedef struct {
    bit          we;
    logic [22:0] adr;
    logic [31:0] data;
    bit          rd;
    bit          fl;
    bit          clr;
    logic [22:0] ca;
    int          e_level;
    bit          e_empty;
    bit          e_ovf;
    bit          e_udf;
    bit          e_hit;
  } vec_t;

  vec_t vecs[9];

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("level", 64'(level), 64'(q.size()));
    check("empty", 64'(ram_dmafifo_empty), 64'(q.size() == 0));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("almost_full", 64'(almost_full), 64'(q.size() >= DEPTH - AFM));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_udf));
    check("chk_hit", 64'(chk_hit), 64'(m_hit));
    check("head_adr", 64'(ram_dmafifo_adr), q.size() > 0 ? 64'(q[0][54:32]) : 64'd0);
    check("head_data", 64'(ram_dmafifo_data), q.size() > 0 ? 64'(q[0][31:0]) : 64'd0);
  endtask

  // Called just after a rising edge: drives one cycle, advances the model, checks after the next edge.
  task automatic cyc(bit we, logic [22:0] a, logic [31:0] d, bit rd, bit fl, bit clr, logic [22:0] ca);
    bit rf;
    bit wf;
    wr_en = we; wr_adr = a; wr_data = d;
    ram_dmafifo_read = rd; flush = fl; clr_err = clr; chk_adr = ca;
    rf = rd && (q.size() > 0);
    wf = we && ((q.size() < DEPTH) || rf);
    m_ovf = (!fl && we && !wf) || (m_ovf && !clr);
    m_udf = (!fl && rd && q.size() == 0) || (m_udf && !clr);
    if (fl) q.delete();
    else begin
      if (rf) void'(q.pop_front());
      if (wf) q.push_back({a, d});
    end
    m_hit = 0;
    foreach (q[i]) if (q[i][54:34] == ca[22:2]) m_hit = 1;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(logic [22:0] ca);
    cyc(0, 23'd0, 32'd0, 0, 0, 0, ca);
  endtask

  task automatic push(logic [22:0] a, logic [31:0] d);
    cyc(1, a, d, 0, 0, 0, 23'h7fffff);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_empty"}, 64'(ram_dmafifo_empty), 64'd1);
    check({tag, "_full"}, 64'(full), 64'd0);
    check({tag, "_afull"}, 64'(almost_full), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_udf"}, 64'(underflow), 64'd0);
    check({tag, "_hit"}, 64'(chk_hit), 64'd0);
    check({tag, "_adr"}, 64'(ram_dmafifo_adr), 64'd0);
    check({tag, "_data"}, 64'(ram_dmafifo_data), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en = 0; wr_adr = '0; wr_data = '0; ram_dmafifo_read = 0;
    flush = 0; clr_err = 0; chk_adr = '0;

    //             we adr        data          rd fl clr chk       lvl emp ovf udf hit
    vecs[0] = '{1, 23'h000100, 32'hDEADBEEF, 0, 0, 0, 23'h000000, 1, 0, 0, 0, 0};
    vecs[1] = '{0, 23'h000000, 32'h00000000, 1, 0, 0, 23'h000000, 0, 1, 0, 0, 0};
    vecs[2] = '{0, 23'h000000, 32'h00000000, 1, 0, 0, 23'h000000, 0, 1, 0, 1, 0};
    vecs[3] = '{1, 23'h000040, 32'h11112222, 1, 0, 1, 23'h000000, 1, 0, 0, 1, 0};
    vecs[4] = '{0, 23'h000000, 32'h00000000, 1, 0, 1, 23'h000000, 0, 1, 0, 0, 0};
    vecs[5] = '{1, 23'h000204, 32'hCAFEF00D, 0, 0, 0, 23'h000206, 1, 0, 0, 0, 1};
    vecs[6] = '{0, 23'h000000, 32'h00000000, 0, 0, 0, 23'h000208, 1, 0, 0, 0, 0};
    vecs[7] = '{0, 23'h000000, 32'h00000000, 0, 0, 0, 23'h000204, 1, 0, 0, 0, 1};
    vecs[8] = '{0, 23'h000000, 32'h00000000, 1, 0, 0, 23'h000204, 0, 1, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Table vectors: basic push/pop, underflow, push+pop on empty, chk_hit query.
    foreach (vecs[k]) begin
      cyc(vecs[k].we, vecs[k].adr, vecs[k].data, vecs[k].rd, vecs[k].fl, vecs[k].clr, vecs[k].ca);
      check($sformatf("vec%0d_level", k), 64'(level), 64'(vecs[k].e_level));
      check($sformatf("vec%0d_empty", k), 64'(ram_dmafifo_empty), 64'(vecs[k].e_empty));
      check($sformatf("vec%0d_ovf", k), 64'(overflow), 64'(vecs[k].e_ovf));
      check($sformatf("vec%0d_udf", k), 64'(underflow), 64'(vecs[k].e_udf));
      check($sformatf("vec%0d_hit", k), 64'(chk_hit), 64'(vecs[k].e_hit));
      if (k == 0) begin
        check("vec0_adr", 64'(ram_dmafifo_adr), 64'h000100);
        check("vec0_data", 64'(ram_dmafifo_data), 64'hDEADBEEF);
      end
    end

    // Fill to almost_full, full, then overflow and clear.
    for (int i = 0; i < 12; i++) push(23'(i * 4), 32'hA000_0000 + 32'(i));
    check("fill12_afull", 64'(almost_full), 64'd1);
    check("fill12_full", 64'(full), 64'd0);
    for (int i = 12; i < 16; i++) push(23'(i * 4), 32'hA000_0000 + 32'(i));
    check("fill16_full", 64'(full), 64'd1);
    push(23'h7ff000, 32'hBADBAD00);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_level", 64'(level), 64'd16);
    cyc(0, 23'd0, 32'd0, 0, 0, 1, 23'd0);
    check("ovf_clr", 64'(overflow), 64'd0);

    // Push+pop at full for a whole lap: level holds at 16, order preserved across wrap.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 23'(23'h1000 + i * 4), 32'hB000_0000 + 32'(i), 1, 0, 0, 23'h1000);
      check("full_pp_level", 64'(level), 64'd16);
    end
    for (int i = 0; i < 16; i++) cyc(0, 23'd0, 32'd0, 1, 0, 0, 23'h1010);
    check("drained_empty", 64'(ram_dmafifo_empty), 64'd1);

    // Flush at full with a pending overflow: flags untouched, FIFO emptied.
    for (int i = 0; i < 17; i++) push(23'(23'h2000 + i * 4), 32'hC000_0000 + 32'(i));
    cyc(1, 23'h2100, 32'h0, 0, 1, 0, 23'h2000);
    check("flush_full_level", 64'(level), 64'd0);
    check("flush_full_ovf", 64'(overflow), 64'd1);
    check("flush_full_hit", 64'(chk_hit), 64'd0);
    cyc(0, 23'd0, 32'd0, 0, 0, 1, 23'd0);
    for (int i = 0; i < 7; i++) push(23'(23'h3000 + i * 4), 32'hD000_0000 + 32'(i));
    cyc(1, 23'h3100, 32'h1, 1, 1, 0, 23'h3000);
    check("flush7_level", 64'(level), 64'd0);
    check("flush7_empty", 64'(ram_dmafifo_empty), 64'd1);
    check("flush7_ovf", 64'(overflow), 64'd0);
    cyc(0, 23'd0, 32'd0, 1, 1, 0, 23'd0);
    check("flush_empty_udf", 64'(underflow), 64'd0);

    // Random concurrent traffic with occasional flush and clear.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 23'($urandom_range(0, 31) * 4), $urandom,
          ($urandom % 3) != 0, ($urandom % 60) == 0, ($urandom % 25) == 0,
          23'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)));
    end

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) push(23'(23'h4000 + i * 4), 32'hE000_0000 + 32'(i));
    push(23'h4100, 32'h0);
    chk_adr = 23'h4000;
    idle(23'h4000);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    q.delete(); m_ovf = 0; m_udf = 0; m_hit = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(23'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
